// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op encodings (MD_MULT .. MD_MTLO); 6 and 7 are reserved
//   - BUSY_W: width of the busy countdown seen by every pipeline register
//   - default busy cycle counts for multiply and divide
package md_pkg;

  localparam int BUSY_W          = 3;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 7;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

endpackage

// File: rtl/md_arith.sv
// md_arith: purely combinational datapath of the multiply/divide unit.
// Produces the value HI/LO will take when the issued op commits.
// Ports:
//   md_op_i     operation code (md_pkg encodings)
//   a_i, b_i    rs/rt operands (dividend/divisor for divides)
//   pend_hi_o   product high half, or remainder
//   pend_lo_o   product low half, or quotient
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       md_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] pend_hi_o,
  output logic [WIDTH-1:0] pend_lo_o
);

  logic               is_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Signed divide is done on magnitudes and the signs are re-applied after.
  // This makes 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0,
  // without ever asking the tools for an overflowing signed division.
  // A zero divisor is replaced by 1 so the divider never sees zero; its
  // result is discarded in favour of the fixed divide-by-zero value.
  always_comb begin
    is_signed = (md_op_i == MD_MULT) || (md_op_i == MD_DIV);
    ext_a     = is_signed ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    ext_b     = is_signed ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    prod      = ext_a * ext_b;

    a_neg = is_signed & a_i[WIDTH-1];
    b_neg = is_signed & b_i[WIDTH-1];
    mag_a = a_neg ? (~a_i + 1'b1) : a_i;
    mag_b = b_neg ? (~b_i + 1'b1) : b_i;
    div_b = (b_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    q_mag = mag_a / div_b;
    r_mag = mag_a % div_b;
    quot  = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem   = a_neg ? (~r_mag + 1'b1) : r_mag;

    pend_hi_o = '0;
    pend_lo_o = '0;
    case (md_op_i)
      MD_MULT, MD_MULTU: begin
        pend_hi_o = prod[2*WIDTH-1:WIDTH];
        pend_lo_o = prod[WIDTH-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b_i == '0) begin
          pend_hi_o = a_i;
          pend_lo_o = '1;
        end else begin
          pend_hi_o = rem;
          pend_lo_o = quot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit beside the EX stage; owns HI/LO.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        issue strobe, sampled only while busy == 0
//   md_op        0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6/7 reserved
//   a, b         operands (a is also the MTHI/MTLO source)
//   busy         remaining cycles of the in-flight op, 0 = idle;
//                pipeline registers hold while it is nonzero
//   hi, lo       architectural HI/LO
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [BUSY_W-1:0] busy,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  logic [BUSY_W-1:0] busy_q, busy_d;
  logic [WIDTH-1:0]  pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]  pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  arith_hi;
  logic [WIDTH-1:0]  arith_lo;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .md_op_i  (md_op),
    .a_i      (a),
    .b_i      (b),
    .pend_hi_o(arith_hi),
    .pend_lo_o(arith_lo)
  );

  // While counting down, start is ignored and the last count commits the
  // pending result, so new HI/LO appear in the same cycle busy reads 0.
  // When idle, start issues: mul/div latch their result and load the
  // counter, MTHI/MTLO write directly, reserved ops do nothing.
  always_comb begin
    busy_d    = busy_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (busy_q != '0) begin
      busy_d = busy_q - 1'b1;
      if (busy_q == BUSY_W'(1)) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          pend_hi_d = arith_hi;
          pend_lo_d = arith_lo;
          busy_d    = BUSY_W'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          pend_hi_d = arith_hi;
          pend_lo_d = arith_lo;
          busy_d    = BUSY_W'(DIV_CYCLES);
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      busy_q    <= busy_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit. Inputs change and outputs
// are sampled on the falling clock edge; expected HI/LO come from a
// reference model using plain 64-bit integer arithmetic.
module tb_md_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  logic [31:0] mHi = 0;
  logic [31:0] mLo = 0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .md_op(md_op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Architectural result of one op and its busy length.
  function automatic void model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] eh, output logic [31:0] el, output int n);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    eh = mHi;
    el = mLo;
    n  = 0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (op)
      3'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; n = 5; end
      3'd1: begin p = {32'b0, av} * {32'b0, bv}; eh = p[63:32]; el = p[31:0]; n = 5; end
      3'd2: begin
        n = 7;
        if (bv == 0) begin eh = av; el = 32'hFFFFFFFF; end
        else begin
          sq = sa / sb;
          sr = sa % sb;
          eh = sr[31:0];
          el = sq[31:0];
        end
      end
      3'd3: begin
        n = 7;
        if (bv == 0) begin eh = av; el = 32'hFFFFFFFF; end
        else begin eh = av % bv; el = av / bv; end
      end
      3'd4: eh = av;
      3'd5: el = av;
      default: ;
    endcase
  endfunction

  // Called at a falling edge; returns at a falling edge after the result
  // is visible. injectAt != 0 drives an MTLO start while busy == injectAt.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                               input int injectAt);
    logic [31:0] eh, el;
    int n;
    model(op, av, bv, eh, el, n);
    start = 1'b1; md_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    for (int k = n; k >= 1; k--) begin
      checkOutput($sformatf("op%0d busy@%0d", op, k), {29'b0, busy}, 32'(k));
      checkOutput($sformatf("op%0d hi hold@%0d", op, k), hi, mHi);
      checkOutput($sformatf("op%0d lo hold@%0d", op, k), lo, mLo);
      if (k == injectAt) begin
        start = 1'b1; md_op = 3'd5; a = 32'h1234;
      end
      @(negedge clk);
      start = 1'b0;
    end
    mHi = eh;
    mLo = el;
    checkOutput($sformatf("op%0d busy done", op), {29'b0, busy}, 32'd0);
    checkOutput($sformatf("op%0d hi", op), hi, mHi);
    checkOutput($sformatf("op%0d lo", op), lo, mLo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    start = 1'b0; md_op = 3'd0; a = '0; b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset busy", {29'b0, busy}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(3'd0, 32'hFFFFFFFE, 32'd3, 0);
    checkOutput("t1 hi", hi, 32'hFFFFFFFF);
    checkOutput("t1 lo", lo, 32'hFFFFFFFA);

    applyStimulus(3'd3, 32'd17, 32'd5, 0);
    checkOutput("t2 divu lo", lo, 32'd3);
    checkOutput("t2 divu hi", hi, 32'd2);
    applyStimulus(3'd2, 32'hFFFFFFEF, 32'd5, 0);
    checkOutput("t2 div lo", lo, 32'hFFFFFFFD);
    checkOutput("t2 div hi", hi, 32'hFFFFFFFE);

    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    checkOutput("t3 ovf lo", lo, 32'h80000000);
    checkOutput("t3 ovf hi", hi, 32'd0);
    applyStimulus(3'd3, 32'd9, 32'd0, 0);
    checkOutput("t3 dz lo", lo, 32'hFFFFFFFF);
    checkOutput("t3 dz hi", hi, 32'd9);
    applyStimulus(3'd2, 32'hFFFFFF00, 32'd0, 0);
    checkOutput("t3 sdz hi", hi, 32'hFFFFFF00);

    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
    checkOutput("t4 hi", hi, 32'hFFFFFFFE);
    checkOutput("t4 lo", lo, 32'h00000001);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      applyStimulus(rop, ra, rb, 0);
    end

    applyStimulus(3'd4, 32'hAAAA0000, 32'd0, 0);
    applyStimulus(3'd5, 32'h00005555, 32'd0, 0);
    checkOutput("t5 hi", hi, 32'hAAAA0000);
    checkOutput("t5 lo", lo, 32'h00005555);
    applyStimulus(3'd6, 32'hDEADBEEF, 32'd1, 0);
    applyStimulus(3'd7, 32'hDEADBEEF, 32'd1, 0);
    checkOutput("rsvd hi", hi, 32'hAAAA0000);

    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6 busy before reset", {29'b0, busy}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6 async busy", {29'b0, busy}, 32'd0);
    checkOutput("t6 async hi", hi, 32'd0);
    checkOutput("t6 async lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t6 idle busy %0d", i), {29'b0, busy}, 32'd0);
      checkOutput($sformatf("t6 idle hi %0d", i), hi, 32'd0);
      checkOutput($sformatf("t6 idle lo %0d", i), lo, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the pipelined CPU; it sits beside the EX stage.
- It drives the 3-bit `busy` countdown that every pipeline register consumes. Those registers hold their value while `busy` is nonzero, so this block is the producer end of that `busy` interface.
- It executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and holds the architectural HI/LO registers.
- MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; legal range 1..7.
- DIV_CYCLES, 7, busy cycles for DIV/DIVU; legal range 1..7.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  issue strobe for the op on `md_op`; the issuing stage drives it only when not stalled.
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved.
- a  input  WIDTH  rs operand; dividend for DIV/DIVU; source for MTHI/MTLO.
- b  input  WIDTH  rt operand; divisor for DIV/DIVU.
- busy  output  3  remaining cycles of the in-flight op; 0 means idle.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Behaviour:
- Reset (rst_n=0, asynchronous): busy=0, hi=0, lo=0, pending result cleared. Reset mid-operation aborts the op; HI/LO stay 0 after release.
- Issue: `start` is sampled at a posedge only when busy==0. While busy!=0, `start` is ignored entirely: no restart, no HI/LO write.
- MULT/MULTU:
  - At the issue edge, the 64-bit product (signed or unsigned) is computed and latched into pending_hi/pending_lo.
  - busy loads MULT_CYCLES.
- DIV/DIVU:
  - At the issue edge, quotient→pending_lo and remainder→pending_hi.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - busy loads DIV_CYCLES.
- Divide by zero: pending_lo = all ones, pending_hi = a. This holds for signed and unsigned; no exception is raised.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): pending_lo=0x80000000, pending_hi=0.
- Countdown: while busy!=0, busy decrements by 1 each posedge.
- Commit: on the edge where busy goes 1→0, hi/lo take the pending values. New HI/LO are therefore visible in the same cycle busy first reads 0.
  - Latency, issue edge to commit edge: N edges, N = MULT_CYCLES or DIV_CYCLES.
- MTHI/MTLO:
  - At the issue edge, hi (or lo) takes `a`; the other register is untouched; busy stays 0.
  - Accepted only when busy==0; otherwise ignored like any start.
- Reserved ops 6/7: start is accepted, but nothing changes and busy stays 0.
- hi/lo change only at a commit edge, an MTHI/MTLO edge, or reset; they are stable during countdown.
- Counter never wraps: when busy is 0 with no issue, it holds 0.
- Single-register discipline: all state updates in one clocked process with asynchronous reset.
- Arithmetic: signed ops sign-extend operands to 2*WIDTH before multiply; unsigned ops zero-extend. The product is kept at full 64 bits.

Decomposition:
- Shared package md_pkg:
  - md_op encodings MD_MULT..MD_MTLO.
  - Busy width constant BUSY_W=3.
  - The default cycle counts.
- One sub-module, md_arith: combinational, takes a, b, md_op and returns pending_hi/pending_lo. It covers signed/unsigned multiply and divide, divide-by-zero and overflow.
- md_unit holds the counter, the pending and HI/LO registers, and the issue/commit control.

Test Plan:
1. MULT a=0xFFFFFFFE (-2), b=3 → busy reads 5,4,3,2,1 on cycles 1..5, then 0; at busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. DIVU a=17, b=5 → busy 7..1, then 0; lo=3, hi=2. DIV a=-17, b=5 → lo=0xFFFFFFFD, hi=0xFFFFFFFE.
3. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=9, b=0 → lo=0xFFFFFFFF, hi=9.
4. Issue MULTU 0xFFFFFFFF×0xFFFFFFFF. At busy=3, assert start with MTLO a=0x1234 → ignored. Final hi=0xFFFFFFFE, lo=0x00000001.
5. MTHI a=0xAAAA0000, then MTLO a=0x5555 on consecutive cycles → busy stays 0; hi=0xAAAA0000, lo=0x5555 one edge after each issue.
6. Start DIV, pull rst_n low asynchronously at busy=4 (between edges) → busy, hi, lo immediately 0. After release with no start: busy stays 0, hi=lo=0.
